// File: rtl/bfly_pair_sr_pkg.sv
// Shared FFT definitions: block geometry, per-stage butterfly distances
// and the complex block type used between pipeline stages.
package bfly_pair_sr_pkg;

    localparam int FFT_DATA_W    = 9;
    localparam int FFT_UNIT_SIZE = 16;

    localparam int FFT_DEPTH_S0 = 16;
    localparam int FFT_DEPTH_S1 = 8;
    localparam int FFT_DEPTH_S2 = 4;
    localparam int FFT_DEPTH_S3 = 2;
    localparam int FFT_DEPTH_S4 = 1;

    typedef struct packed {
        logic [FFT_UNIT_SIZE-1:0][FFT_DATA_W-1:0] re;
        logic [FFT_UNIT_SIZE-1:0][FFT_DATA_W-1:0] im;
    } cplx_blk_t;

    // Index width that stays legal for the single-block stage.
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/bfly_pair_sr_mem.sv
// First-half block store: register array, one write port and one
// combinational read port.
module bfly_pair_mem #(
    parameter int DEPTH = 16,
    parameter int W     = 288,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/bfly_pair_sr.sv
// Pairs each second-half block of a frame with its buffered first-half
// partner so the next butterfly sees aligned operands.
module bfly_pair_sr
    import bfly_pair_sr_pkg::*;
#(
    parameter  int DATA_W    = FFT_DATA_W,
    parameter  int UNIT_SIZE = FFT_UNIT_SIZE,
    parameter  int DEPTH     = FFT_DEPTH_S0,
    localparam int IDX_W     = idx_w(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     din_valid,
    input  logic signed [DATA_W-1:0] din_real [0:UNIT_SIZE-1],
    input  logic signed [DATA_W-1:0] din_imag [0:UNIT_SIZE-1],
    output logic                     valid_out,
    output logic signed [DATA_W-1:0] sr_real  [0:UNIT_SIZE-1],
    output logic signed [DATA_W-1:0] sr_imag  [0:UNIT_SIZE-1],
    output logic signed [DATA_W-1:0] org_real [0:UNIT_SIZE-1],
    output logic signed [DATA_W-1:0] org_imag [0:UNIT_SIZE-1],
    output logic [IDX_W-1:0]         pair_idx,
    output logic                     frame_done
);

    localparam int CW = $clog2(2 * DEPTH);
    localparam int LW = UNIT_SIZE * DATA_W;
    localparam int MW = 2 * LW;

    logic [CW-1:0]    blk_cnt_q, blk_cnt_d;
    logic             valid_q, valid_d;
    logic             fdone_q, fdone_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic signed [DATA_W-1:0] sr_re_q  [UNIT_SIZE];
    logic signed [DATA_W-1:0] sr_im_q  [UNIT_SIZE];
    logic signed [DATA_W-1:0] org_re_q [UNIT_SIZE];
    logic signed [DATA_W-1:0] org_im_q [UNIT_SIZE];
    logic signed [DATA_W-1:0] sr_re_d  [UNIT_SIZE];
    logic signed [DATA_W-1:0] sr_im_d  [UNIT_SIZE];
    logic signed [DATA_W-1:0] org_re_d [UNIT_SIZE];
    logic signed [DATA_W-1:0] org_im_d [UNIT_SIZE];

    logic             pair_ph;
    logic [IDX_W-1:0] slot;
    logic             wr_en;
    logic [MW-1:0]    wr_data;
    logic [MW-1:0]    rd_data;

    // Counter MSB is the phase; low bits address the partner slot.
    assign pair_ph = blk_cnt_q[CW-1];
    assign slot    = IDX_W'(blk_cnt_q & CW'(DEPTH - 1));
    assign wr_en   = din_valid & ~pair_ph;

    always_comb begin
        wr_data = '0;
        for (int i = 0; i < UNIT_SIZE; i++) begin
            wr_data[i*DATA_W +: DATA_W]      = din_real[i];
            wr_data[LW + i*DATA_W +: DATA_W] = din_imag[i];
        end
    end

    bfly_pair_mem #(
        .DEPTH (DEPTH),
        .W     (MW),
        .AW    (IDX_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (slot),
        .wdata (wr_data),
        .raddr (slot),
        .rdata (rd_data)
    );

    always_comb begin
        blk_cnt_d = blk_cnt_q;
        valid_d   = 1'b0;
        fdone_d   = 1'b0;
        idx_d     = idx_q;
        sr_re_d   = sr_re_q;
        sr_im_d   = sr_im_q;
        org_re_d  = org_re_q;
        org_im_d  = org_im_q;
        if (din_valid) begin
            blk_cnt_d = blk_cnt_q + CW'(1);
            if (pair_ph) begin
                valid_d = 1'b1;
                idx_d   = slot;
                fdone_d = (slot == IDX_W'(DEPTH - 1));
                for (int i = 0; i < UNIT_SIZE; i++) begin
                    sr_re_d[i]  = rd_data[i*DATA_W +: DATA_W];
                    sr_im_d[i]  = rd_data[LW + i*DATA_W +: DATA_W];
                    org_re_d[i] = din_real[i];
                    org_im_d[i] = din_imag[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt_q <= '0;
            valid_q   <= 1'b0;
            fdone_q   <= 1'b0;
            idx_q     <= '0;
            sr_re_q   <= '{default: '0};
            sr_im_q   <= '{default: '0};
            org_re_q  <= '{default: '0};
            org_im_q  <= '{default: '0};
        end else begin
            blk_cnt_q <= blk_cnt_d;
            valid_q   <= valid_d;
            fdone_q   <= fdone_d;
            idx_q     <= idx_d;
            sr_re_q   <= sr_re_d;
            sr_im_q   <= sr_im_d;
            org_re_q  <= org_re_d;
            org_im_q  <= org_im_d;
        end
    end

    assign valid_out  = valid_q;
    assign frame_done = fdone_q;
    assign pair_idx   = idx_q;
    assign sr_real    = sr_re_q;
    assign sr_imag    = sr_im_q;
    assign org_real   = org_re_q;
    assign org_imag   = org_im_q;

endmodule

// File: tb/tb_bfly_pair_sr.sv
// Scoreboard bench for bfly_pair_sr: a DEPTH=16 and a DEPTH=1 instance
// share one input stream, each checked against its own pairing model.
module tb_bfly_pair_sr;

    localparam int W  = 9;
    localparam int U  = 16;
    localparam int LW = U * W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic din_valid = 1'b0;
    logic signed [W-1:0] din_real [U];
    logic signed [W-1:0] din_imag [U];

    logic                v16, fd16;
    logic [3:0]          idx16;
    logic signed [W-1:0] sr_r16 [U];
    logic signed [W-1:0] sr_i16 [U];
    logic signed [W-1:0] or_r16 [U];
    logic signed [W-1:0] or_i16 [U];

    logic                v1, fd1;
    logic [0:0]          idx1;
    logic signed [W-1:0] sr_r1 [U];
    logic signed [W-1:0] sr_i1 [U];
    logic signed [W-1:0] or_r1 [U];
    logic signed [W-1:0] or_i1 [U];

    always #5 clk = ~clk;

    bfly_pair_sr #(.DATA_W(W), .UNIT_SIZE(U), .DEPTH(16)) dut16 (
        .clk(clk), .rst(rst), .din_valid(din_valid),
        .din_real(din_real), .din_imag(din_imag),
        .valid_out(v16), .sr_real(sr_r16), .sr_imag(sr_i16),
        .org_real(or_r16), .org_imag(or_i16),
        .pair_idx(idx16), .frame_done(fd16)
    );

    bfly_pair_sr #(.DATA_W(W), .UNIT_SIZE(U), .DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .din_valid(din_valid),
        .din_real(din_real), .din_imag(din_imag),
        .valid_out(v1), .sr_real(sr_r1), .sr_imag(sr_i1),
        .org_real(or_r1), .org_imag(or_i1),
        .pair_idx(idx1), .frame_done(fd1)
    );

    typedef struct {
        logic [LW-1:0] sr_r;
        logic [LW-1:0] sr_i;
        logic [LW-1:0] org_r;
        logic [LW-1:0] org_i;
        int            idx;
        bit            fd;
    } pair_t;

    pair_t q16[$];
    pair_t q1[$];
    pair_t h16, h1, zero_p;
    logic [LW-1:0] b16_r [16];
    logic [LW-1:0] b16_i [16];
    logic [LW-1:0] b1_r, b1_i;
    int c16, c1;
    bit e16, e1;
    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [LW-1:0] pk(input logic signed [W-1:0] a [U]);
        logic [LW-1:0] r;
        for (int l = 0; l < U; l++) r[l*W +: W] = a[l];
        return r;
    endfunction

    function automatic logic [LW-1:0] mk_r(input int n);
        logic [LW-1:0] r;
        r[0 +: W] = W'(n);
        for (int l = 1; l < U; l++) r[l*W +: W] = W'(n * 37 + l * 11);
        return r;
    endfunction

    function automatic logic [LW-1:0] mk_i(input int n);
        logic [LW-1:0] r;
        r[0 +: W] = W'(-n);
        for (int l = 1; l < U; l++) r[l*W +: W] = ~W'(n * 5 + l * 3);
        return r;
    endfunction

    // Extreme lanes: +255 is 9'h0FF, -256 is 9'h100.
    function automatic logic [LW-1:0] ext(input int n, input bit inv);
        logic [LW-1:0] r;
        for (int l = 0; l < U; l++)
            r[l*W +: W] = (((n >> (l % 4)) & 1) ^ int'(inv)) != 0
                          ? 9'h0FF : 9'h100;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [LW-1:0] o,
                       input logic [LW-1:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic model_reset();
        c16 = 0;
        c1  = 0;
        q16.delete();
        q1.delete();
        h16 = zero_p;
        h1  = zero_p;
    endtask

    task automatic check_out();
        if (e16) h16 = q16.pop_front();
        if (e1)  h1  = q1.pop_front();
        chk("valid16", LW'(v16), LW'(e16));
        chk("fdone16", LW'(fd16), LW'(e16 && h16.fd));
        if (e16) chk("idx16", LW'(idx16), LW'(h16.idx));
        chk("sr_re16", pk(sr_r16), h16.sr_r);
        chk("sr_im16", pk(sr_i16), h16.sr_i);
        chk("org_re16", pk(or_r16), h16.org_r);
        chk("org_im16", pk(or_i16), h16.org_i);
        chk("valid1", LW'(v1), LW'(e1));
        chk("fdone1", LW'(fd1), LW'(e1 && h1.fd));
        if (e1) chk("idx1", LW'(idx1), LW'(h1.idx));
        chk("sr_re1", pk(sr_r1), h1.sr_r);
        chk("sr_im1", pk(sr_i1), h1.sr_i);
        chk("org_re1", pk(or_r1), h1.org_r);
        chk("org_im1", pk(or_i1), h1.org_i);
    endtask

    task automatic step(input bit v, input logic [LW-1:0] r,
                        input logic [LW-1:0] im);
        pair_t p;
        @(negedge clk);
        din_valid = v;
        for (int l = 0; l < U; l++) begin
            din_real[l] = r[l*W +: W];
            din_imag[l] = im[l*W +: W];
        end
        e16 = 1'b0;
        e1  = 1'b0;
        if (v) begin
            if (c16 < 16) begin
                b16_r[c16] = r;
                b16_i[c16] = im;
            end else begin
                p.sr_r  = b16_r[c16-16];
                p.sr_i  = b16_i[c16-16];
                p.org_r = r;
                p.org_i = im;
                p.idx   = c16 - 16;
                p.fd    = (c16 == 31);
                q16.push_back(p);
                e16 = 1'b1;
            end
            c16 = (c16 + 1) % 32;
            if (c1 == 0) begin
                b1_r = r;
                b1_i = im;
            end else begin
                p.sr_r  = b1_r;
                p.sr_i  = b1_i;
                p.org_r = r;
                p.org_i = im;
                p.idx   = 0;
                p.fd    = 1'b1;
                q1.push_back(p);
                e1 = 1'b1;
            end
            c1 = 1 - c1;
        end
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        din_valid = 1'b0;
        model_reset();
        e16 = 1'b0;
        e1  = 1'b0;
        #1;
        chk("idx16_async_rst", LW'(idx16), '0);
        @(posedge clk);
        #1;
        check_out();
        chk("idx16_rst", LW'(idx16), '0);
        chk("idx1_rst", LW'(idx1), '0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        zero_p.sr_r  = '0;
        zero_p.sr_i  = '0;
        zero_p.org_r = '0;
        zero_p.org_i = '0;
        zero_p.idx   = 0;
        zero_p.fd    = 1'b0;
        for (int l = 0; l < U; l++) begin
            din_real[l] = '0;
            din_imag[l] = '0;
        end
        model_reset();
        #2 rst = 1'b1;
        do_reset();

        // Two back-to-back frames at full rate.
        for (int k = 0; k < 64; k++) step(1'b1, mk_r(k), mk_i(k));

        // One frame with a bubble every third cycle; bubble data is junk.
        n = 64;
        for (int k = 0; n < 96; k++) begin
            if (k % 3 == 2) step(1'b0, mk_r(500 + k), mk_i(500 + k));
            else begin
                step(1'b1, mk_r(n), mk_i(n));
                n++;
            end
        end

        // Full-scale lanes of both signs.
        for (int k = 0; k < 32; k++) step(1'b1, ext(k, 1'b0), ext(k, 1'b1));

        // Partial frame discarded by a reset, then a fresh frame.
        for (int k = 0; k < 20; k++) step(1'b1, mk_r(200 + k), mk_i(200 + k));
        do_reset();
        for (int k = 0; k < 32; k++) step(1'b1, mk_r(100 + k), mk_i(100 + k));

        for (int k = 0; k < 3; k++) step(1'b0, mk_r(7), mk_i(7));
        chk("q16_drained", LW'(q16.size()), '0);
        chk("q1_drained", LW'(q1.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
